// File: rtl/csh_dir.sv
// Set-associative cache directory for the MBOX: valid/tag/parity flops, registered
// lookup with per-way match, multi-hit and parity-error flags, plus an invalidate sweep.
//
// state | meaning
// IDLE  | no sweep; lookups see the directory
// RUN   | clearing one set per cycle (a write steals the cycle)
// DONE  | final cycle of the sweep, SWEEP_DONE pulses
module csh_dir #(
  parameter  int WAYS  = 4,
  parameter  int SET_W = 7,
  parameter  int TAG_W = 13,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int ADR_W = TAG_W + SET_W + 2
) (
  input  logic             clk,
  input  logic             CROBAR,
  input  logic             LK_REQ,
  input  logic [ADR_W-1:0] LK_ADR,
  output logic [WAYS-1:0]  VALID_MATCH,
  output logic             LK_DONE,
  output logic             ADR_PAR_BAD,
  output logic             MULTI_HIT,
  input  logic             WR_EN,
  input  logic [WAY_W-1:0] WR_WAY,
  input  logic [SET_W-1:0] WR_SET,
  input  logic [TAG_W-1:0] WR_TAG,
  input  logic             WR_VALID,
  input  logic             WR_BAD_PAR,
  input  logic             SWEEP_START,
  output logic             SWEEP_BUSY,
  output logic             SWEEP_DONE
);

  localparam int SETS = 2 ** SET_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [SET_W-1:0] cnt, cnt_nxt;
  logic             sweep_step;

  logic [WAYS-1:0]  vld_q [SETS];
  logic [WAYS-1:0]  par_q [SETS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];

  logic             wr_ok;
  logic [SET_W-1:0] lk_set;
  logic [TAG_W-1:0] lk_tag;
  logic [WAYS-1:0]  hit;
  logic             par_bad;

  assign wr_ok  = WR_EN && (32'(WR_WAY) < 32'(WAYS));
  assign lk_set = LK_ADR[SET_W+1:2];
  assign lk_tag = LK_ADR[ADR_W-1:SET_W+2];

  assign SWEEP_BUSY = (state != IDLE);
  assign SWEEP_DONE = (state == DONE);

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A directory write in the same cycle pre-empts the sweep step.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sweep_step = 1'b0;
    case (state)
      IDLE: begin
        if (SWEEP_START) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!WR_EN) begin
          sweep_step = 1'b1;
          cnt_nxt    = cnt + SET_W'(1);
          if (cnt == {SET_W{1'b1}}) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        par_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      if (sweep_step) vld_q[cnt] <= '0;
      if (wr_ok) begin
        vld_q[WR_SET][WR_WAY] <= WR_VALID;
        tag_q[WR_SET][WR_WAY] <= WR_TAG;
        par_q[WR_SET][WR_WAY] <= (^WR_TAG) ^ WR_BAD_PAR;
      end
    end
  end

  always_comb begin
    hit     = '0;
    par_bad = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        if ((^tag_q[lk_set][w]) == par_q[lk_set][w]) hit[w] = 1'b1;
        else                                         par_bad = 1'b1;
      end
    end
  end

  // Results are taken from pre-edge storage, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      LK_DONE     <= 1'b0;
      VALID_MATCH <= '0;
      MULTI_HIT   <= 1'b0;
      ADR_PAR_BAD <= 1'b0;
    end else begin
      LK_DONE <= LK_REQ;
      if (LK_REQ && (state == IDLE)) begin
        VALID_MATCH <= hit;
        MULTI_HIT   <= ($countones(hit) > 1);
        ADR_PAR_BAD <= par_bad;
      end else begin
        VALID_MATCH <= '0;
        MULTI_HIT   <= 1'b0;
        ADR_PAR_BAD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csh_dir.sv
// Scoreboard bench for csh_dir: a behavioural directory model predicts each lookup
// result and the sweep busy/done outputs; a negedge monitor compares them.
module tb_csh_dir;
  localparam int WAYS  = 4;
  localparam int SET_W = 7;
  localparam int TAG_W = 13;
  localparam int SETS  = 128;
  localparam int ADR_W = 22;

  logic             clk = 1'b0;
  logic             CROBAR = 1'b1;
  logic             LK_REQ = 1'b0;
  logic [ADR_W-1:0] LK_ADR = '0;
  logic [WAYS-1:0]  VALID_MATCH;
  logic             LK_DONE, ADR_PAR_BAD, MULTI_HIT;
  logic             WR_EN = 1'b0;
  logic [1:0]       WR_WAY = '0;
  logic [SET_W-1:0] WR_SET = '0;
  logic [TAG_W-1:0] WR_TAG = '0;
  logic             WR_VALID = 1'b0, WR_BAD_PAR = 1'b0, SWEEP_START = 1'b0;
  logic             SWEEP_BUSY, SWEEP_DONE;

  csh_dir #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .CROBAR(CROBAR), .LK_REQ(LK_REQ), .LK_ADR(LK_ADR),
    .VALID_MATCH(VALID_MATCH), .LK_DONE(LK_DONE), .ADR_PAR_BAD(ADR_PAR_BAD),
    .MULTI_HIT(MULTI_HIT), .WR_EN(WR_EN), .WR_WAY(WR_WAY), .WR_SET(WR_SET),
    .WR_TAG(WR_TAG), .WR_VALID(WR_VALID), .WR_BAD_PAR(WR_BAD_PAR),
    .SWEEP_START(SWEEP_START), .SWEEP_BUSY(SWEEP_BUSY), .SWEEP_DONE(SWEEP_DONE)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each entry holds, and how far the sweep has got.
  bit mv   [SETS][WAYS];
  int mt   [SETS][WAYS];
  bit mbad [SETS][WAYS];
  bit sweeping = 1'b0;
  bit done_now = 1'b0;
  int sweep_next = 0;

  typedef struct {
    int             due;
    logic [WAYS-1:0] match;
    logic           multi;
    logic           pbad;
  } exp_t;
  exp_t q[$];

  function automatic void mdl_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0; mt[s][w] = 0; mbad[s][w] = 1'b0;
      end
    sweeping = 1'b0; done_now = 1'b0; sweep_next = 0;
  endfunction

  function automatic exp_t mdl_lookup(input int adr);
    exp_t e;
    int tag, set, n;
    tag = adr / (1 << (SET_W + 2));
    set = (adr / 4) % SETS;
    e.match = '0; e.multi = 1'b0; e.pbad = 1'b0; e.due = 0;
    n = 0;
    if (!(sweeping || done_now)) begin
      for (int w = 0; w < WAYS; w++)
        if (mv[set][w] && mt[set][w] == tag) begin
          if (mbad[set][w]) e.pbad = 1'b1;
          else begin e.match[w] = 1'b1; n++; end
        end
    end
    e.multi = (n > 1);
    return e;
  endfunction

  function automatic void mdl_edge();
    if (done_now) done_now = 1'b0;
    else if (sweeping) begin
      if (!WR_EN) begin
        for (int w = 0; w < WAYS; w++) mv[sweep_next][w] = 1'b0;
        sweep_next++;
        if (sweep_next == SETS) begin sweeping = 1'b0; done_now = 1'b1; end
      end
    end else if (SWEEP_START) begin
      sweeping = 1'b1; sweep_next = 0;
    end
    if (WR_EN && int'(WR_WAY) < WAYS) begin
      mv[WR_SET][WR_WAY]   = WR_VALID;
      mt[WR_SET][WR_WAY]   = int'(WR_TAG);
      mbad[WR_SET][WR_WAY] = WR_BAD_PAR;
    end
  endfunction

  // Monitor: a lookup result is due in exactly the cycle recorded in the queue.
  int run_len = 0;
  int last_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("lk_done", LK_DONE, 1);
      chk("valid_match", VALID_MATCH, e.match);
      chk("multi_hit", MULTI_HIT, e.multi);
      chk("adr_par_bad", ADR_PAR_BAD, e.pbad);
    end else begin
      chk("no_lk_done", LK_DONE, 0);
      chk("quiet_outputs", {VALID_MATCH, MULTI_HIT, ADR_PAR_BAD}, 0);
    end
    chk("sweep_busy", SWEEP_BUSY, (sweeping || done_now));
    chk("sweep_done", SWEEP_DONE, done_now);
    if (SWEEP_BUSY) run_len++;
    else if (run_len != 0) begin last_len = run_len; run_len = 0; end
  end

  task automatic tick();
    exp_t e;
    if (LK_REQ) begin
      e = mdl_lookup(int'(LK_ADR));
      e.due = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic quiet();
    LK_REQ = 0; WR_EN = 0; WR_BAD_PAR = 0; SWEEP_START = 0; WR_VALID = 0;
  endtask

  function automatic logic [ADR_W-1:0] adr_of(input int tag, input int set, input int word);
    return ADR_W'(tag * (1 << (SET_W + 2)) + (set % SETS) * 4 + (word % 4));
  endfunction

  task automatic set_wr(input int way, input int set, input int tag, input bit v, input bit bp);
    WR_EN = 1; WR_WAY = 2'(way); WR_SET = SET_W'(set); WR_TAG = TAG_W'(tag);
    WR_VALID = v; WR_BAD_PAR = bp;
  endtask

  task automatic wr(input int way, input int set, input int tag, input bit v, input bit bp);
    set_wr(way, set, tag, v, bp); tick(); quiet();
  endtask

  task automatic lk(input int tag, input int set, input int word);
    LK_REQ = 1; LK_ADR = adr_of(tag, set, word); tick(); quiet();
  endtask

  task automatic do_reset();
    CROBAR = 1;
    mdl_clear();
    q.delete();
    #1;
    chk("reset_busy", SWEEP_BUSY, 0);
    chk("reset_done", SWEEP_DONE, 0);
    repeat (2) @(posedge clk);
    #1;
    CROBAR = 0;
  endtask

  task automatic fill3();
    int sets[3] = '{0, 'h40, 'h7F};
    foreach (sets[i])
      for (int w = 0; w < WAYS; w++) wr(w, sets[i], 'h100 + w, 1, 0);
  endtask

  task automatic start_sweep();
    last_len = 0;
    SWEEP_START = 1; tick(); quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    LK_REQ = 1; LK_ADR = '1; tick(); quiet();

    wr(2, 'h15, 'h0ABC, 1, 0);
    lk('h0ABC, 'h15, 3);
    lk('h0ABD, 'h15, 3);

    wr(0, 7, 'h0123, 1, 0);
    wr(3, 7, 'h0123, 1, 0);
    lk('h0123, 7, 0);
    wr(3, 7, 'h0123, 1, 1);
    lk('h0123, 7, 1);

    set_wr(2, 'h15, 'h0ABC, 0, 0);
    LK_REQ = 1; LK_ADR = adr_of('h0ABC, 'h15, 0);
    tick(); quiet();
    lk('h0ABC, 'h15, 0);

    fill3();
    start_sweep();
    for (int k = 1; k < 200 && last_len == 0; k++) begin
      if (k % 37 == 0) begin LK_REQ = 1; LK_ADR = adr_of('h100 + k % 4, (k % 2) ? 'h7F : 'h40, 0); end
      tick(); quiet();
    end
    chk("sweep_len", last_len, 129);
    for (int w = 0; w < WAYS; w++) begin
      lk('h100 + w, 0, 0); lk('h100 + w, 'h40, 1); lk('h100 + w, 'h7F, 2);
    end

    start_sweep();
    for (int k = 1; k < 200 && last_len == 0; k++) begin
      if (k == 10 || k == 20 || k == 30) set_wr(k / 10, k / 10, 'h200 + k, 1, 0);
      tick(); quiet();
    end
    chk("sweep_len_writes", last_len, 132);
    for (int k = 1; k <= 3; k++) lk('h200 + 10 * k, k, 0);

    fill3();
    start_sweep();
    repeat (49) tick();
    do_reset();
    lk('h100, 0, 0); lk('h101, 'h40, 0); lk('h0123, 7, 0);
    last_len = 0;
    start_sweep();
    for (int k = 1; k < 200 && last_len == 0; k++) tick();
    chk("sweep_len_after_reset", last_len, 129);

    for (int i = 0; i < 1500; i++) begin
      LK_REQ = 1'($urandom_range(0, 1));
      LK_ADR = adr_of($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        set_wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0));
      SWEEP_START = 1'($urandom_range(0, 299) == 0);
      tick(); quiet();
    end

    repeat (3) tick();
    chk("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
